// File: rtl/nmcu_pkg.sv
// Shared types and helpers for the NMCU bank crossbar.
// Bank FSM states, bank-bit and index-width helpers, flattened-bus slice macro.
`ifndef NMCU_SLICE
`define NMCU_SLICE(v, k, w) v[(k)*(w) +: (w)]
`endif

package nmcu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } bank_st_e;

  function automatic int bb_of(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic int iw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nmcu_rr_arbiter.sv
// Round-robin pick: first request at or after ptr_i, wrapping at N.
// Ports: req_i, ptr_i in; gnt_vld_o, gnt_oh_o (one-hot), gnt_idx_o out.
module nmcu_rr_arbiter
  import nmcu_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = iw_of(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_vld_o,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk offsets from far to near so the nearest hit is written last.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    sum       = '0;
    idx       = '0;
    for (int o = N - 1; o >= 0; o--) begin
      sum = {1'b0, ptr_i} + (IW+1)'(o);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (req_i[idx]) begin
        gnt_vld_o     = 1'b1;
        gnt_oh_o      = '0;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/nmcu_bank_xbar.sv
// NMCU-to-bank crossbar: address-interleaved banks, one RR arbiter + FSM per bank.
// Ports: NMCU request/response side, bank strobe side, busy; stat_conflicts with NMCU_XBAR_STATS_EN.
module nmcu_bank_xbar
  import nmcu_pkg::*;
#(
  parameter int NUM_NMCUS     = 196,
  parameter int NUM_BANKS     = 4,
  parameter int ADDR_WIDTH    = 16,
  parameter int DATABUS_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_NMCUS-1:0]               nmcu_mem_sel,
  input  logic [NUM_NMCUS-1:0]               nmcu_mem_w,
  input  logic [NUM_NMCUS*ADDR_WIDTH-1:0]    nmcu_addr_bus,
  input  logic [NUM_NMCUS*DATABUS_WIDTH-1:0] nmcu_wdata,
  output logic [NUM_NMCUS*DATABUS_WIDTH-1:0] nmcu_rdata,
  output logic [NUM_NMCUS-1:0]               nmcu_mem_ready,
  output logic [NUM_BANKS-1:0]               bank_sel,
  output logic [NUM_BANKS-1:0]               bank_w,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]    bank_addr,
  output logic [NUM_BANKS*DATABUS_WIDTH-1:0] bank_wdata,
  input  logic [NUM_BANKS*DATABUS_WIDTH-1:0] bank_rdata,
  input  logic [NUM_BANKS-1:0]               bank_ready,
  output logic                               busy
`ifdef NMCU_XBAR_STATS_EN
  ,output logic [NUM_BANKS*32-1:0]           stat_conflicts
`endif
);

  localparam int NN = NUM_NMCUS;
  localparam int NB = NUM_BANKS;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATABUS_WIDTH;
  localparam int BB = bb_of(NB);
  localparam int IW = iw_of(NN);

  logic [NB-1:0][NN-1:0] cand;
  logic [NB-1:0][IW-1:0] gidx;
  logic [NB-1:0][DW-1:0] rdq;
  logic [NB-1:0]         resp;
  logic [NB-1:0]         act;

  // Low address bits pick the bank; NB-1 masks to zero when NB=1.
  always_comb begin
    cand = '0;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < NN; k++)
        cand[b][k] = nmcu_mem_sel[k] &&
          ((`NMCU_SLICE(nmcu_addr_bus, k, AW) & AW'(NB-1)) == AW'(b));
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    bank_st_e      st_q, st_d;
    logic [IW-1:0] rr_q, rr_d, gnt_q, gnt_d;
    logic          w_q, w_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] wd_q, wd_d, rd_q, rd_d;
    logic          av;
    logic [NN-1:0] aoh;
    logic [IW-1:0] aidx;

    nmcu_rr_arbiter #(.N(NN), .IW(IW)) u_arb (
      .req_i     (cand[b]),
      .ptr_i     (rr_q),
      .gnt_vld_o (av),
      .gnt_oh_o  (aoh),
      .gnt_idx_o (aidx)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= ST_IDLE;
        rr_q  <= '0;
        gnt_q <= '0;
        w_q   <= 1'b0;
        a_q   <= '0;
        wd_q  <= '0;
        rd_q  <= '0;
      end else begin
        st_q  <= st_d;
        rr_q  <= rr_d;
        gnt_q <= gnt_d;
        w_q   <= w_d;
        a_q   <= a_d;
        wd_q  <= wd_d;
        rd_q  <= rd_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      rr_d  = rr_q;
      gnt_d = gnt_q;
      w_d   = w_q;
      a_d   = a_q;
      wd_d  = wd_q;
      rd_d  = rd_q;
      unique case (st_q)
        ST_IDLE: begin
          if (av) begin
            st_d  = ST_BUSY;
            gnt_d = aidx;
            w_d   = 1'b0;
            a_d   = '0;
            wd_d  = '0;
            // One-hot AND-OR mux of the granted requester's fields.
            for (int k = 0; k < NN; k++) begin
              if (aoh[k]) begin
                w_d  = w_d | nmcu_mem_w[k];
                a_d  = a_d | (`NMCU_SLICE(nmcu_addr_bus, k, AW) >> BB);
                wd_d = wd_d | `NMCU_SLICE(nmcu_wdata, k, DW);
              end
            end
          end
        end
        ST_BUSY: begin
          if (bank_ready[b]) begin
            rd_d = w_q ? '0 : `NMCU_SLICE(bank_rdata, b, DW);
            st_d = ST_RESP;
          end
        end
        ST_RESP: begin
          rr_d = (gnt_q == IW'(NN-1)) ? '0 : gnt_q + IW'(1);
          st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end

    assign bank_sel[b]                 = (st_q == ST_BUSY);
    assign bank_w[b]                   = w_q;
    assign bank_addr[b*AW +: AW]       = a_q;
    assign bank_wdata[b*DW +: DW]      = wd_q;
    assign resp[b]                     = (st_q == ST_RESP);
    assign act[b]                      = (st_q != ST_IDLE);
    assign gidx[b]                     = gnt_q;
    assign rdq[b]                      = rd_q;

`ifdef NMCU_XBAR_STATS_EN
    logic [31:0]   cnt_q, cnt_d;
    logic [NN-1:0] oth;
    logic          hit;

    // IDLE: >=2 candidates; otherwise any candidate besides the grant.
    always_comb begin
      oth = cand[b];
      hit = 1'b0;
      if (st_q == ST_IDLE) begin
        hit = (cand[b] & (cand[b] - NN'(1))) != '0;
      end else begin
        oth[gnt_q] = 1'b0;
        hit        = |oth;
      end
      cnt_d = (hit && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign stat_conflicts[b*32 +: 32] = cnt_q;
`endif
  end

  assign busy = |act;

  always_comb begin
    nmcu_mem_ready = '0;
    nmcu_rdata     = '0;
    for (int k = 0; k < NN; k++) begin
      for (int b = 0; b < NB; b++) begin
        if (resp[b] && (gidx[b] == IW'(k))) begin
          nmcu_mem_ready[k]         = 1'b1;
          nmcu_rdata[k*DW +: DW]    = nmcu_rdata[k*DW +: DW] | rdq[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_nmcu_bank_xbar.sv
// Directed bench for nmcu_bank_xbar: 4 NMCUs, 4 banks, programmable-latency bank model.
// Optional stats check when NMCU_XBAR_STATS_EN is defined.
module tb_nmcu_bank_xbar;

  localparam int NN = 4;
  localparam int NB = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NN-1:0]     sel, wr;
  logic [NN*AW-1:0]  addr;
  logic [NN*DW-1:0]  wdata;
  logic [NN*DW-1:0]  rdata;
  logic [NN-1:0]     rdy;
  logic [NB-1:0]     bsel, bw, brdy;
  logic [NB*AW-1:0]  baddr;
  logic [NB*DW-1:0]  bwdata, brdata;
  logic              busy;
`ifdef NMCU_XBAR_STATS_EN
  logic [NB*32-1:0]  stats;
`endif

  int checks = 0;
  int errs   = 0;
  int lat [NB];
  logic [NB-1:0][7:0] wc;

  nmcu_bank_xbar #(
    .NUM_NMCUS(NN), .NUM_BANKS(NB),
    .ADDR_WIDTH(AW), .DATABUS_WIDTH(DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .nmcu_mem_sel   (sel),
    .nmcu_mem_w     (wr),
    .nmcu_addr_bus  (addr),
    .nmcu_wdata     (wdata),
    .nmcu_rdata     (rdata),
    .nmcu_mem_ready (rdy),
    .bank_sel       (bsel),
    .bank_w         (bw),
    .bank_addr      (baddr),
    .bank_wdata     (bwdata),
    .bank_rdata     (brdata),
    .bank_ready     (brdy),
    .busy           (busy)
`ifdef NMCU_XBAR_STATS_EN
    ,.stat_conflicts(stats)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bank model: ready after lat[b] wait cycles, rdata tagged with bank and local addr.
  always @(posedge clk or posedge rst) begin
    if (rst) wc <= '0;
    else
      for (int b = 0; b < NB; b++)
        wc[b] <= (bsel[b] && !brdy[b]) ? wc[b] + 8'd1 : 8'd0;
  end

  always @* begin
    brdy   = '0;
    brdata = '0;
    for (int b = 0; b < NB; b++) begin
      brdy[b] = bsel[b] && (int'(wc[b]) >= lat[b]);
      brdata[b*DW +: DW] = 32'hB000_0000 | (32'(b) << 24) |
                           32'(baddr[b*AW +: AW]);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    sel[k]             = s;
    wr[k]              = w;
    addr[k*AW +: AW]   = a;
    wdata[k*DW +: DW]  = d;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [NN-1:0] exp_rdy;
    rst   = 1'b1;
    sel   = '0;
    wr    = '0;
    addr  = '0;
    wdata = '0;
    for (int b = 0; b < NB; b++) lat[b] = 0;
    repeat (2) cyc();
    chk("rst_rdy", 128'(rdy), 128'h0);
    chk("rst_bsel", 128'(bsel), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    rst = 1'b0;
    cyc();
    chk("rst_rdata", 128'(rdata), 128'h0);

    // Single read to bank 1
    set_req(0, 1'b1, 1'b0, 16'h0105, 32'h0);
    cyc();
    chk("t1_bsel", 128'(bsel), 128'h2);
    chk("t1_baddr", 128'(baddr[31:16]), 128'h41);
    chk("t1_bw", 128'(bw[1]), 128'h0);
    chk("t1_busy", 128'(busy), 128'h1);
    chk("t1_rdy_c1", 128'(rdy), 128'h0);
    cyc();
    chk("t1_rdy", 128'(rdy), 128'h1);
    chk("t1_rdata", 128'(rdata[31:0]), 128'hB100_0041);
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();
    chk("t1_rdy_off", 128'(rdy), 128'h0);
    chk("t1_rdata_off", 128'(rdata), 128'h0);
    chk("t1_idle", 128'(busy), 128'h0);

    // Two banks in parallel
    set_req(0, 1'b1, 1'b0, 16'h0100, 32'h0);
    set_req(1, 1'b1, 1'b0, 16'h0101, 32'h0);
    cyc();
    chk("t2_bsel", 128'(bsel), 128'h3);
    chk("t2_baddr", 128'(baddr[31:0]), 128'h0040_0040);
    cyc();
    chk("t2_rdy", 128'(rdy), 128'h3);
    chk("t2_rdata", 128'(rdata[63:0]), 128'hB100_0040_B000_0040);
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();

    // Slow bank write
    lat[3] = 3;
    set_req(3, 1'b1, 1'b1, 16'h0123, 32'hDEAD_BEEF);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("t4_bsel_c%0d", c), 128'(bsel), 128'h8);
      chk($sformatf("t4_baddr_c%0d", c), 128'(baddr[63:48]), 128'h48);
      chk($sformatf("t4_wdata_c%0d", c), 128'(bwdata[127:96]), 128'hDEAD_BEEF);
      chk($sformatf("t4_bw_c%0d", c), 128'(bw[3]), 128'h1);
      chk($sformatf("t4_rdy_c%0d", c), 128'(rdy), 128'h0);
    end
    cyc();
    chk("t4_rdy", 128'(rdy), 128'h8);
    chk("t4_rdata", 128'(rdata[127:96]), 128'h0);
    set_req(3, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();
    chk("t4_bsel_off", 128'(bsel), 128'h0);
    chk("t4_rdy_off", 128'(rdy), 128'h0);
    lat[3] = 0;

    // Reset in the middle of a bank access
    lat[0] = 5;
    set_req(1, 1'b1, 1'b0, 16'h0000, 32'h0);
    cyc();
    chk("t5_bsel", 128'(bsel), 128'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5_bsel_rst", 128'(bsel), 128'h0);
    chk("t5_busy_rst", 128'(busy), 128'h0);
    chk("t5_rdy_rst", 128'(rdy), 128'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();
    rst    = 1'b0;
    lat[0] = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("t5_norsp_%0d", c), 128'(rdy), 128'h0);
    end

    // Three requesters on bank 0, continuously
    set_req(0, 1'b1, 1'b0, 16'h0000, 32'h0);
    set_req(1, 1'b1, 1'b0, 16'h0004, 32'h0);
    set_req(2, 1'b1, 1'b0, 16'h0008, 32'h0);
    for (int c = 0; c < 12; c++) begin
      exp_rdy = '0;
      if (c % 3 == 2) exp_rdy[(c / 3) % 3] = 1'b1;
      chk($sformatf("t3_rdy_c%0d", c), 128'(rdy), 128'(exp_rdy));
      if (c % 3 == 2)
        chk($sformatf("t3_rdata_c%0d", c),
            128'(rdata[((c / 3) % 3)*DW +: DW]),
            128'(32'hB000_0000 | 32'((c / 3) % 3)));
      cyc();
    end
    sel = '0;
    cyc();
    chk("t3_idle", 128'(busy), 128'h0);

`ifdef NMCU_XBAR_STATS_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0002, 32'h0);
    set_req(1, 1'b1, 1'b0, 16'h0006, 32'h0);
    set_req(2, 1'b1, 1'b0, 16'h000A, 32'h0);
    repeat (9) cyc();
    sel = '0;
    repeat (2) cyc();
    chk("t6_stat2", 128'(stats[95:64]), 128'd9);
    chk("t6_stat_oth", 128'({stats[127:96], stats[63:0]}), 128'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
